// File: rtl/mult_seq_if.sv
// Handshake bundle for the sequential multiplier: start/operands in, busy/done/product out.
interface mult_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic               is_signed;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] z;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, z
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, z
    );
endinterface

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier for MULT/MULTU; retires BITS_PER_CYCLE multiplier
// bits per RUN cycle and writes a full 2*WIDTH product with a one-cycle done pulse.
module mult_seq #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic       clk,
    input logic       reset,
    mult_seq_if.slave bus
);
    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [PW-1:0]    partial;

    // Magnitudes are unsigned WIDTH-bit, so |min int| fits and the 2*WIDTH accumulator
    // can never overflow.
    always_comb begin
        partial = PW'(mag_a_q) * PW'(mag_b_q[BITS_PER_CYCLE-1:0]);
    end

    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mag_a_d = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                    mag_b_d = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                    neg_d   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d   = acc_q + (partial << (BITS_PER_CYCLE * 32'(cnt_q)));
                mag_b_d = mag_b_q >> BITS_PER_CYCLE;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                z_d     = neg_q ? -acc_q : acc_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // FIN still counts as busy, so a start there is dropped.
    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.z    = z_q;
endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed MULT/MULTU cases on a radix-1 build and a random
// back-to-back run on a radix-4 build, both checked against an arithmetic reference.
module tb_mult_seq;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mult_seq_if #(.WIDTH(32)) mif1 ();
    mult_seq_if #(.WIDTH(32)) mif4 ();

    mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(mif1));
    mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .bus(mif4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] x,
                                             input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (sg) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    // One radix-1 op; inject drops extra starts into RUN and into the FIN cycle.
    task automatic op1(input logic sg, input logic [31:0] x, input logic [31:0] y,
                       input bit inject, output logic [63:0] zo);
        int lat;
        int bc;
        mif1.start     = 1'b1;
        mif1.is_signed = sg;
        mif1.a         = x;
        mif1.b         = y;
        tick();
        mif1.start = 1'b0;
        mif1.a     = $urandom();
        mif1.b     = $urandom();
        bc  = int'(mif1.busy);
        lat = 0;
        while (!mif1.done && lat < 100) begin
            mif1.start = inject && (lat == 4 || lat == 32);
            mif1.is_signed = ~sg;
            tick();
            lat++;
            bc += int'(mif1.busy);
        end
        mif1.start = 1'b0;
        zo = mif1.z;
        check("latency1", 64'(lat), 64'd33);
        check("busy_cycles1", 64'(bc), 64'd33);
        tick();
        check("done_pulse", {63'b0, mif1.done}, 64'd0);
        check("busy_after_done", {63'b0, mif1.busy}, 64'd0);
        check("z_hold", mif1.z, zo);
    endtask

    initial begin
        logic [63:0] zr;
        logic [63:0] prev;
        logic [63:0] exp;
        logic [31:0] x;
        logic [31:0] y;
        logic        sg;
        int          lat;

        reset = 1'b0;
        mif1.start = 1'b0; mif1.is_signed = 1'b0; mif1.a = '0; mif1.b = '0;
        mif4.start = 1'b0; mif4.is_signed = 1'b0; mif4.a = '0; mif4.b = '0;
        tick();
        tick();
        check("rst_z1", mif1.z, 64'd0);
        check("rst_busy1", {63'b0, mif1.busy}, 64'd0);
        check("rst_done1", {63'b0, mif1.done}, 64'd0);
        check("rst_z4", mif4.z, 64'd0);
        check("rst_busy4", {63'b0, mif4.busy}, 64'd0);
        check("rst_done4", {63'b0, mif4.done}, 64'd0);
        reset = 1'b1;
        tick();

        op1(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, zr);
        check("multu_ones", zr, 64'hFFFF_FFFE_0000_0001);
        op1(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, zr);
        check("mult_m3x5", zr, 64'hFFFF_FFFF_FFFF_FFF1);
        op1(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, zr);
        check("mult_min", zr, 64'h4000_0000_0000_0000);
        op1(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, zr);
        check("mult_m1", zr, 64'd1);
        op1(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, zr);
        check("multu_ones2", zr, 64'hFFFF_FFFE_0000_0001);
        op1(1'b1, 32'd7, 32'hFFFF_FFF7, 1'b1, zr);
        check("ignored_starts", zr, 64'hFFFF_FFFF_FFFF_FFC1);

        // Abort mid-op with reset; the earlier product must survive until then.
        prev = zr;
        mif1.start = 1'b1; mif1.is_signed = 1'b0; mif1.a = 32'd1234; mif1.b = 32'd5678;
        tick();
        mif1.start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            tick();
            if (i == 5) check("z_stable_run", mif1.z, prev);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", {63'b0, mif1.busy}, 64'd0);
        check("abort_done", {63'b0, mif1.done}, 64'd0);
        check("abort_z", mif1.z, 64'd0);
        op1(1'b0, 32'd1234, 32'd5678, 1'b0, zr);
        check("after_abort", zr, 64'd7006652);

        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom());
            x  = pick();
            y  = pick();
            op1(sg, x, y, 1'b0, zr);
            check("rand1", zr, ref_prod(sg, x, y));
        end

        // Radix-4: every new start lands in the done cycle of the previous op.
        for (int i = 0; i < 2000; i++) begin
            sg = 1'($urandom());
            x  = pick();
            y  = pick();
            exp = ref_prod(sg, x, y);
            mif4.start = 1'b1; mif4.is_signed = sg; mif4.a = x; mif4.b = y;
            tick();
            mif4.start = 1'b0;
            mif4.a = $urandom();
            mif4.b = $urandom();
            lat = 0;
            while (!mif4.done && lat < 50) begin
                tick();
                lat++;
            end
            check("rand4_z", mif4.z, exp);
            check("rand4_latency", 64'(lat), 64'd9);
        end
        tick();
        check("rand4_done_pulse", {63'b0, mif4.done}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
